buzzer_mode_ctrl: RTL and testbench

Mode controller and arbiter for the shared buzzer and LED bar. It has three requesters: free-play keyboard, auto-play song engine and learning mode. The block owns the current mode and the play/pause state it hands to the auto-play engine, and inserts a silent gap on every mode change. It sits between the three mode datapaths and the buzzer driver / LED outputs.

---
 rtl/buzzer_mode_ctrl.sv | 142 ++++++++++++++
 tb/tb_buzzer_mode_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/buzzer_mode_ctrl.sv
// Mode controller / arbiter for the shared buzzer and LED bar: owns the current
// mode and play/pause state, and inserts a silent gap on every mode change.
module buzzer_mode_ctrl #(
   parameter int unsigned MUTE_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       play_btn,
   input  logic [3:0] free_note,
   input  logic [1:0] free_octave,
   input  logic [6:0] free_led,
   input  logic [3:0] auto_note,
   input  logic [1:0] auto_octave,
   input  logic [6:0] auto_led,
   input  logic [3:0] learn_note,
   input  logic [1:0] learn_octave,
   input  logic [6:0] learn_led,
   output logic [3:0] note_out,
   output logic [1:0] octave_out,
   output logic [6:0] led_out,
   output logic       play_state,
   output logic [1:0] mode,
   output logic       muting
);

   // Mode-state encodings match the tgt encoding so MUTE can exit with state <= tgt.
   localparam logic [1:0] S_FREE  = 2'b00;
   localparam logic [1:0] S_AUTO  = 2'b01;
   localparam logic [1:0] S_LEARN = 2'b10;
   localparam logic [1:0] S_MUTE  = 2'b11;

   localparam logic [23:0] RELOAD = 24'(MUTE_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  tgt;
   logic [23:0] cnt;
   logic        mode_q;
   logic        play_q;
   logic        mode_edge;
   logic        play_edge;

   logic [3:0]  note_nxt;
   logic [1:0]  octave_nxt;
   logic [6:0]  led_nxt;

   function automatic logic [1:0] next_mode(input logic [1:0] cur);
      case (cur)
         S_FREE:  next_mode = S_AUTO;
         S_AUTO:  next_mode = S_LEARN;
         default: next_mode = S_FREE;
      endcase
   endfunction

   always_comb begin
      mode_edge = mode_btn & ~mode_q;
      play_edge = play_btn & ~play_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q     <= 1'b1;
         play_q     <= 1'b1;
         state      <= S_FREE;
         tgt        <= S_FREE;
         cnt        <= '0;
         play_state <= 1'b0;
      end else begin
         mode_q <= mode_btn;
         play_q <= play_btn;
         case (state)
            S_MUTE: begin
               play_state <= 1'b0;
               if (mode_edge) begin
                  tgt <= next_mode(tgt);
                  cnt <= RELOAD;
               end else if (cnt == '0) begin
                  state <= tgt;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            default: begin
               // A mode edge wins over a coincident play edge, which is dropped.
               if (mode_edge) begin
                  tgt        <= next_mode(tgt);
                  cnt        <= RELOAD;
                  state      <= S_MUTE;
                  play_state <= 1'b0;
               end else if (play_edge && state != S_FREE) begin
                  play_state <= ~play_state;
               end
            end
         endcase
      end
   end

   always_comb begin
      note_nxt   = '0;
      octave_nxt = '0;
      led_nxt    = '0;
      case (state)
         S_FREE: begin
            note_nxt   = free_note;
            octave_nxt = free_octave;
            led_nxt    = free_led;
         end
         S_AUTO: begin
            if (play_state) begin
               note_nxt   = auto_note;
               octave_nxt = auto_octave;
               led_nxt    = auto_led;
            end
         end
         S_LEARN: begin
            if (play_state) begin
               note_nxt   = learn_note;
               octave_nxt = learn_octave;
               led_nxt    = learn_led;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         note_out   <= '0;
         octave_out <= '0;
         led_out    <= '0;
         muting     <= 1'b0;
      end else begin
         note_out   <= note_nxt;
         octave_out <= octave_nxt;
         led_out    <= led_nxt;
         muting     <= (state == S_MUTE);
      end
   end

   assign mode = tgt;

endmodule

// File: tb/tb_buzzer_mode_ctrl.sv
// Scoreboard bench for buzzer_mode_ctrl: stimulus pushes per-cycle expectations,
// a monitor pops and compares them after each rising clock edge.
module tb_buzzer_mode_ctrl;

   localparam int K_REST  = 0;
   localparam int K_FREE  = 1;
   localparam int K_AUTO  = 2;
   localparam int K_LEARN = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mode_btn = 1'b0;
   logic       play_btn = 1'b0;
   logic [3:0] free_note = 4'd3;
   logic [1:0] free_octave = 2'd1;
   logic [6:0] free_led = 7'h11;
   logic [3:0] auto_note = 4'd5;
   logic [1:0] auto_octave = 2'd2;
   logic [6:0] auto_led = 7'h2A;
   logic [3:0] learn_note = 4'd9;
   logic [1:0] learn_octave = 2'd3;
   logic [6:0] learn_led = 7'h55;
   logic [3:0] note_out;
   logic [1:0] octave_out;
   logic [6:0] led_out;
   logic       play_state;
   logic [1:0] mode;
   logic       muting;

   typedef struct {
      int         id;
      logic [3:0] note;
      logic [1:0] oct;
      logic [6:0] led;
      logic       ps;
      logic [1:0] md;
      logic       mut;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   step_id = 0;

   buzzer_mode_ctrl #(.MUTE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .mode_btn(mode_btn), .play_btn(play_btn),
      .free_note(free_note), .free_octave(free_octave), .free_led(free_led),
      .auto_note(auto_note), .auto_octave(auto_octave), .auto_led(auto_led),
      .learn_note(learn_note), .learn_octave(learn_octave), .learn_led(learn_led),
      .note_out(note_out), .octave_out(octave_out), .led_out(led_out),
      .play_state(play_state), .mode(mode), .muting(muting)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int id, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h expected=%0h", name, id, act, expv);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the outputs
   // must show after the following rising edge.
   task automatic step(input logic rst, input logic mb, input logic pb,
                       input int kind, input logic ps, input logic [1:0] md,
                       input logic mut);
      exp_t e;
      @(negedge clk);
      reset    = rst;
      mode_btn = mb;
      play_btn = pb;
      step_id++;
      e.id  = step_id;
      e.ps  = ps;
      e.md  = md;
      e.mut = mut;
      case (kind)
         K_FREE:  begin e.note = 4'd3; e.oct = 2'd1; e.led = 7'h11; end
         K_AUTO:  begin e.note = 4'd5; e.oct = 2'd2; e.led = 7'h2A; end
         K_LEARN: begin e.note = 4'd9; e.oct = 2'd3; e.led = 7'h55; end
         default: begin e.note = 4'd0; e.oct = 2'd0; e.led = 7'h00; end
      endcase
      exp_q.push_back(e);
   endtask

   task automatic check_reset_now(input int id);
      cmp("rst_note", id, int'(note_out), 0);
      cmp("rst_octave", id, int'(octave_out), 0);
      cmp("rst_led", id, int'(led_out), 0);
      cmp("rst_play_state", id, int'(play_state), 0);
      cmp("rst_mode", id, int'(mode), 0);
      cmp("rst_muting", id, int'(muting), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("note_out", e.id, int'(note_out), int'(e.note));
            cmp("octave_out", e.id, int'(octave_out), int'(e.oct));
            cmp("led_out", e.id, int'(led_out), int'(e.led));
            cmp("play_state", e.id, int'(play_state), int'(e.ps));
            cmp("mode", e.id, int'(mode), int'(e.md));
            cmp("muting", e.id, int'(muting), int'(e.mut));
         end
      end
   end

   initial begin : stimulus
      mode_btn = 1'b1;
      play_btn = 1'b1;
      #2 reset = 1'b0;
      #1 check_reset_now(0);
      step(1'b0, 1'b1, 1'b1, K_REST, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, K_REST, 1'b0, 2'd0, 1'b0);
      // Release with both buttons held: no edge, FREE passthrough.
      step(1'b1, 1'b1, 1'b1, K_FREE, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, K_FREE, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_FREE, 1'b0, 2'd0, 1'b0);
      // FREE -> MUTE(4) -> AUTO.
      step(1'b1, 1'b1, 1'b0, K_FREE, 1'b0, 2'd1, 1'b0);
      step(1'b1, 1'b1, 1'b0, K_REST, 1'b0, 2'd1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd1, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd1, 1'b0);
      // Play toggling in AUTO, including a held play_btn.
      step(1'b1, 1'b0, 1'b1, K_REST, 1'b1, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b1, K_AUTO, 1'b1, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_AUTO, 1'b1, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b1, K_AUTO, 1'b0, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b1, K_REST, 1'b1, 2'd1, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_AUTO, 1'b1, 2'd1, 1'b0);
      // Simultaneous mode and play edges: mode taken, play dropped.
      step(1'b1, 1'b1, 1'b1, K_AUTO, 1'b0, 2'd2, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd2, 1'b1);
      step(1'b1, 1'b0, 1'b1, K_REST, 1'b0, 2'd2, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd2, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd2, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd2, 1'b0);
      // LEARN playback.
      step(1'b1, 1'b0, 1'b1, K_REST, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_LEARN, 1'b1, 2'd2, 1'b0);
      // LEARN -> MUTE, second mode edge two cycles in reloads the gap.
      step(1'b1, 1'b1, 1'b0, K_LEARN, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd0, 1'b1);
      step(1'b1, 1'b1, 1'b0, K_REST, 1'b0, 2'd1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd1, 1'b1);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd1, 1'b0);
      // AUTO -> MUTE then asynchronous reset mid-gap.
      step(1'b1, 1'b1, 1'b0, K_REST, 1'b0, 2'd2, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_REST, 1'b0, 2'd2, 1'b1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1 check_reset_now(-1);
      step(1'b0, 1'b0, 1'b0, K_REST, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_FREE, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, K_FREE, 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
